// File: rtl/hazard_scoreboard_pkg.sv
// Shared definitions for the hazard scoreboard.
// Holds the parameter defaults, the per-stage entry record and the halt FSM
// state encoding. Contains no ports.
package hazard_scoreboard_pkg;

  localparam int unsigned DATA_W_DEF      = 16;
  localparam int unsigned REG_AW_DEF      = 3;
  localparam int unsigned DEPTH_DEF       = 3;
  localparam int unsigned LOAD_STAGE_DEF  = 2;
  localparam int unsigned FLUSH_STAGE_DEF = 2;

  // The entry record stores destinations at this fixed width so the type can
  // live in the package. REG_AW must not exceed it.
  localparam int unsigned MAX_REG_AW = 8;

  typedef struct packed {
    logic                  valid;
    logic [MAX_REG_AW-1:0] dst;
    logic                  wr;
    logic                  is_load;
    logic                  halt;
  } entry_t;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } halt_state_e;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode/hazard bus of the hazard scoreboard.
// master: the pipeline side that drives the decode instruction, flush and
//         stage results, and receives stall/forward/halt status.
// slave : the scoreboard itself.
interface hazard_scoreboard_if #(
  parameter int unsigned DATA_W = hazard_scoreboard_pkg::DATA_W_DEF,
  parameter int unsigned REG_AW = hazard_scoreboard_pkg::REG_AW_DEF,
  parameter int unsigned DEPTH  = hazard_scoreboard_pkg::DEPTH_DEF
) ();
  localparam int unsigned SEL_W = $clog2(DEPTH + 1);

  logic                    id_valid;
  logic [REG_AW-1:0]       id_src1;
  logic [REG_AW-1:0]       id_src2;
  logic                    id_use1;
  logic                    id_use2;
  logic [REG_AW-1:0]       id_dst;
  logic                    id_wr;
  logic                    id_is_load;
  logic                    id_halt;
  logic                    flush;
  logic [DEPTH*DATA_W-1:0] stage_data;
  logic                    stall;
  logic [SEL_W-1:0]        fwd_sel1;
  logic [SEL_W-1:0]        fwd_sel2;
  logic [DATA_W-1:0]       fwd_data1;
  logic [DATA_W-1:0]       fwd_data2;
  logic                    halted;
  logic                    err;

  modport master (
    output id_valid, id_src1, id_src2, id_use1, id_use2, id_dst, id_wr,
           id_is_load, id_halt, flush, stage_data,
    input  stall, fwd_sel1, fwd_sel2, fwd_data1, fwd_data2, halted, err
  );

  modport slave (
    input  id_valid, id_src1, id_src2, id_use1, id_use2, id_dst, id_wr,
           id_is_load, id_halt, flush, stage_data,
    output stall, fwd_sel1, fwd_sel2, fwd_data1, fwd_data2, halted, err
  );
endinterface

// File: rtl/hazard_scoreboard_match.sv
// hazard_match: matches one decode source register against the stage pipe.
// Ports: use_i/src_i   - source-read flag and register address
//        pipe_i        - stage entries, index 1 = EX (youngest)
//        sel_o         - youngest forwarding stage, 0 = register file
//        load_use_o    - source depends on a load whose data is not ready
module hazard_match
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned REG_AW     = REG_AW_DEF,
  parameter int unsigned DEPTH      = DEPTH_DEF,
  parameter int unsigned LOAD_STAGE = LOAD_STAGE_DEF,
  parameter int unsigned SEL_W      = $clog2(DEPTH + 1)
) (
  input  logic               use_i,
  input  logic [REG_AW-1:0]  src_i,
  input  entry_t [DEPTH:1]   pipe_i,
  output logic [SEL_W-1:0]   sel_o,
  output logic               load_use_o
);
  logic [DEPTH:1] match;
  logic           found;

  always_comb begin
    match      = '0;
    sel_o      = '0;
    load_use_o = 1'b0;
    found      = 1'b0;
    for (int unsigned k = 1; k <= DEPTH; k++) begin
      match[k] = use_i & pipe_i[k].valid & pipe_i[k].wr &
                 (pipe_i[k].dst == MAX_REG_AW'(src_i));
      if (match[k] && pipe_i[k].is_load && (k < LOAD_STAGE)) load_use_o = 1'b1;
      // Youngest match owns the value; an unready load there forwards nothing.
      if (match[k] && !found) begin
        found = 1'b1;
        if (!(pipe_i[k].is_load && (k < LOAD_STAGE))) sel_o = SEL_W'(k);
      end
    end
  end
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks in-flight instructions after decode, raises
// load-use stalls, selects forwarding sources and runs the halt drain FSM.
// Ports: clk - rising-edge clock; rst - synchronous active-high reset;
//        bus - hazard_scoreboard_if.slave (decode instruction, flush,
//              stage results in; stall, forward selects/data, halted, err out)
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned REG_AW      = REG_AW_DEF,
  parameter int unsigned DEPTH       = DEPTH_DEF,
  parameter int unsigned LOAD_STAGE  = LOAD_STAGE_DEF,
  parameter int unsigned FLUSH_STAGE = FLUSH_STAGE_DEF
) (
  input logic                clk,
  input logic                rst,
  hazard_scoreboard_if.slave bus
);
  localparam int unsigned SEL_W = $clog2(DEPTH + 1);

  entry_t [DEPTH:1]  pipe_q, pipe_d;
  halt_state_e       state_q, state_d;
  logic              err_q, err_d;
  logic [SEL_W-1:0]  sel1, sel2;
  logic              lu1, lu2;
  logic              stall, issue, halt_killed, halt_retire;
  logic [DATA_W-1:0] data1, data2;

  hazard_match #(
    .REG_AW(REG_AW), .DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE), .SEL_W(SEL_W)
  ) u_match1 (
    .use_i(bus.id_use1), .src_i(bus.id_src1), .pipe_i(pipe_q),
    .sel_o(sel1), .load_use_o(lu1)
  );

  hazard_match #(
    .REG_AW(REG_AW), .DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE), .SEL_W(SEL_W)
  ) u_match2 (
    .use_i(bus.id_use2), .src_i(bus.id_src2), .pipe_i(pipe_q),
    .sel_o(sel2), .load_use_o(lu2)
  );

  always_comb begin
    stall = (state_q != ST_RUN) | (bus.id_valid & (lu1 | lu2));
    issue = bus.id_valid & ~stall & ~bus.flush;
  end

  always_comb begin
    pipe_d      = '0;
    halt_killed = 1'b0;
    for (int unsigned k = 2; k <= DEPTH; k++) pipe_d[k] = pipe_q[k-1];
    // Squash the instructions younger than the redirecting stage as they shift.
    if (bus.flush) begin
      for (int unsigned k = 1; (k < FLUSH_STAGE) && (k < DEPTH); k++) begin
        halt_killed       = halt_killed | (pipe_q[k].valid & pipe_q[k].halt);
        pipe_d[k+1].valid = 1'b0;
      end
    end
    if (issue) begin
      pipe_d[1].valid   = 1'b1;
      pipe_d[1].dst     = MAX_REG_AW'(bus.id_dst);
      pipe_d[1].wr      = bus.id_wr;
      pipe_d[1].is_load = bus.id_is_load;
      pipe_d[1].halt    = bus.id_halt;
    end
    halt_retire = pipe_q[DEPTH].valid & pipe_q[DEPTH].halt;
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    case (state_q)
      ST_RUN:    if (issue && bus.id_halt) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (halt_killed)      state_d = ST_RUN;
        else if (halt_retire) state_d = ST_HALTED;
        if (bus.id_valid && bus.id_halt) err_d = 1'b1;
      end
      ST_HALTED: if (bus.flush) err_d = 1'b1;
      default:   state_d = ST_RUN;
    endcase
  end

  always_comb begin
    data1 = '0;
    data2 = '0;
    for (int unsigned k = 1; k <= DEPTH; k++) begin
      if (sel1 == SEL_W'(k)) data1 = bus.stage_data[(k-1)*DATA_W +: DATA_W];
      if (sel2 == SEL_W'(k)) data2 = bus.stage_data[(k-1)*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_q  <= '0;
      state_q <= ST_RUN;
      err_q   <= 1'b0;
    end else begin
      pipe_q  <= pipe_d;
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  assign bus.stall     = stall;
  assign bus.fwd_sel1  = sel1;
  assign bus.fwd_sel2  = sel2;
  assign bus.fwd_data1 = data1;
  assign bus.fwd_data2 = data2;
  assign bus.halted    = (state_q == ST_HALTED);
  assign bus.err       = err_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;
  localparam int DW = 16;
  localparam int AW = 3;
  localparam int DP = 3;
  localparam int LS = 2;
  localparam int FS = 2;
  localparam logic [15:0] D1 = 16'h1234;
  localparam logic [15:0] D2 = 16'hBEEF;
  localparam logic [15:0] D3 = 16'h3333;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  hazard_scoreboard_if #(.DATA_W(DW), .REG_AW(AW), .DEPTH(DP)) bus ();

  hazard_scoreboard #(
    .DATA_W(DW), .REG_AW(AW), .DEPTH(DP), .LOAD_STAGE(LS), .FLUSH_STAGE(FS)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] s1, input logic u1,
                       input logic [2:0] s2, input logic u2, input logic [2:0] dst,
                       input logic wr, input logic ld, input logic hlt, input logic fl);
    bus.id_valid = v;  bus.id_src1 = s1; bus.id_use1 = u1;
    bus.id_src2 = s2;  bus.id_use2 = u2; bus.id_dst = dst;
    bus.id_wr = wr;    bus.id_is_load = ld; bus.id_halt = hlt; bus.flush = fl;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- reference model: instruction occupying each stage ----
  typedef struct {
    bit v; int dst; bit wr; bit ld; bit h;
  } ins_t;
  ins_t stg[1:DP];
  int   m_mode;   // 0 running, 1 draining, 2 halted
  bit   m_err;

  function automatic void m_reset();
    for (int k = 1; k <= DP; k++) stg[k] = '{0, 0, 0, 0, 0};
    m_mode = 0;
    m_err  = 0;
  endfunction

  function automatic bit m_hit(int k, int src, bit u);
    return u && stg[k].v && stg[k].wr && (stg[k].dst == src);
  endfunction

  function automatic int m_sel(int src, bit u);
    for (int k = 1; k <= DP; k++)
      if (m_hit(k, src, u)) return (stg[k].ld && k < LS) ? 0 : k;
    return 0;
  endfunction

  function automatic bit m_stall();
    bit lu = 0;
    if (m_mode != 0) return 1;
    for (int k = 1; k < LS && k <= DP; k++)
      if (stg[k].ld && (m_hit(k, int'(bus.id_src1), bus.id_use1) ||
                        m_hit(k, int'(bus.id_src2), bus.id_use2))) lu = 1;
    return bus.id_valid && lu;
  endfunction

  function automatic logic [15:0] m_data(int sel);
    logic [47:0] sd = bus.stage_data;
    return (sel == 0) ? 16'h0 : sd[(sel-1)*16 +: 16];
  endfunction

  task automatic m_check();
    int s1 = m_sel(int'(bus.id_src1), bus.id_use1);
    int s2 = m_sel(int'(bus.id_src2), bus.id_use2);
    chk("rnd_stall",  32'(bus.stall),     32'(m_stall()));
    chk("rnd_sel1",   32'(bus.fwd_sel1),  32'(s1));
    chk("rnd_sel2",   32'(bus.fwd_sel2),  32'(s2));
    chk("rnd_data1",  32'(bus.fwd_data1), 32'(m_data(s1)));
    chk("rnd_data2",  32'(bus.fwd_data2), 32'(m_data(s2)));
    chk("rnd_halted", 32'(bus.halted),    32'(m_mode == 2));
    chk("rnd_err",    32'(bus.err),       32'(m_err));
  endtask

  function automatic void m_advance();
    bit issued, killed, retire;
    if (rst) begin
      m_reset();
      return;
    end
    issued = bus.id_valid && !m_stall() && !bus.flush;
    killed = 0;
    retire = stg[DP].v && stg[DP].h;
    if (bus.flush)
      for (int k = 1; k < FS && k < DP; k++) begin
        if (stg[k].v && stg[k].h) killed = 1;
        stg[k].v = 0;
      end
    if (m_mode == 2 && bus.flush) m_err = 1;
    if (m_mode == 1 && bus.id_valid && bus.id_halt) m_err = 1;
    if (m_mode == 0 && issued && bus.id_halt) m_mode = 1;
    else if (m_mode == 1 && killed) m_mode = 0;
    else if (m_mode == 1 && retire) m_mode = 2;
    for (int k = DP; k >= 2; k--) stg[k] = stg[k-1];
    stg[1] = issued ? '{1, int'(bus.id_dst), bus.id_wr, bus.id_is_load, bus.id_halt}
                    : '{0, 0, 0, 0, 0};
  endfunction

  // ---------------- directed table ----------------
  typedef struct {
    logic v; logic [2:0] s1; logic u1; logic [2:0] s2; logic u2;
    logic [2:0] dst; logic wr; logic ld; logic fl;
    logic e_stall; logic [1:0] e_sel1; logic [1:0] e_sel2;
    logic [15:0] e_d1; logic [15:0] e_d2;
  } vec_t;
  vec_t tbl[15];

  initial begin
    int hcnt;
    rst = 1'b0;
    idle();
    bus.stage_data = {D3, D2, D1};

    tbl[0]  = '{1, 0, 0, 0, 0, 1, 1, 0, 0,  0, 0, 0, 16'h0, 16'h0};  // ADD r1
    tbl[1]  = '{1, 1, 1, 0, 0, 5, 1, 0, 0,  0, 1, 0, D1,    16'h0};  // reads r1 from EX
    tbl[2]  = '{1, 0, 0, 0, 0, 2, 1, 1, 0,  0, 0, 0, 16'h0, 16'h0};  // LD r2
    tbl[3]  = '{1, 2, 1, 0, 0, 6, 1, 0, 0,  1, 0, 0, 16'h0, 16'h0};  // load-use stall
    tbl[4]  = '{1, 2, 1, 0, 0, 6, 1, 0, 0,  0, 2, 0, D2,    16'h0};  // load data from stage 2
    tbl[5]  = '{1, 0, 0, 0, 0, 3, 1, 0, 0,  0, 0, 0, 16'h0, 16'h0};  // r3 writer (old)
    tbl[6]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 16'h0, 16'h0};
    tbl[7]  = '{1, 0, 0, 0, 0, 3, 1, 0, 0,  0, 0, 0, 16'h0, 16'h0};  // r3 writer (new)
    tbl[8]  = '{1, 1, 1, 3, 1, 0, 0, 0, 0,  0, 0, 1, 16'h0, D1   };  // youngest r3 wins
    tbl[9]  = '{1, 3, 1, 0, 0, 0, 1, 0, 0,  0, 2, 0, D2,    16'h0};  // r3 in stage 2; writes r0
    tbl[10] = '{1, 0, 1, 0, 0, 7, 0, 0, 0,  0, 1, 0, D1,    16'h0};  // r0 is matchable
    tbl[11] = '{1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 16'h0, 16'h0};  // use=0 never matches
    tbl[12] = '{1, 0, 0, 0, 0, 4, 1, 1, 0,  0, 0, 0, 16'h0, 16'h0};  // LD r4
    tbl[13] = '{1, 4, 1, 0, 0, 0, 0, 0, 1,  1, 0, 0, 16'h0, 16'h0};  // stall + flush together
    tbl[14] = '{1, 4, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 16'h0, 16'h0};  // LD squashed, no stall

    do_reset();
    #2;
    chk("reset_stall",  32'(bus.stall),     0);
    chk("reset_sel1",   32'(bus.fwd_sel1),  0);
    chk("reset_sel2",   32'(bus.fwd_sel2),  0);
    chk("reset_data1",  32'(bus.fwd_data1), 0);
    chk("reset_data2",  32'(bus.fwd_data2), 0);
    chk("reset_halted", 32'(bus.halted),    0);
    chk("reset_err",    32'(bus.err),       0);

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].s1, tbl[i].u1, tbl[i].s2, tbl[i].u2, tbl[i].dst,
            tbl[i].wr, tbl[i].ld, 1'b0, tbl[i].fl);
      #2;
      chk($sformatf("tbl%0d_stall", i), 32'(bus.stall),     32'(tbl[i].e_stall));
      chk($sformatf("tbl%0d_sel1", i),  32'(bus.fwd_sel1),  32'(tbl[i].e_sel1));
      chk($sformatf("tbl%0d_sel2", i),  32'(bus.fwd_sel2),  32'(tbl[i].e_sel2));
      chk($sformatf("tbl%0d_data1", i), 32'(bus.fwd_data1), 32'(tbl[i].e_d1));
      chk($sformatf("tbl%0d_data2", i), 32'(bus.fwd_data2), 32'(tbl[i].e_d2));
      tick();
    end

    // Halt: stall from next cycle, halted three edges after issue, then
    // flush while halted sets a sticky err.
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    #2 chk("halt_issue_stall", 32'(bus.stall), 0);
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      #2;
      chk($sformatf("drain%0d_stall", i),  32'(bus.stall),  1);
      chk($sformatf("drain%0d_halted", i), 32'(bus.halted), 0);
      tick();
    end
    #2 chk("halted_set", 32'(bus.halted), 1);
    chk("halted_stall", 32'(bus.stall), 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    #2 chk("err_before_flush", 32'(bus.err), 0);
    tick();
    idle();
    #2 chk("err_set", 32'(bus.err), 1);
    chk("halted_persist", 32'(bus.halted), 1);
    tick();
    #2 chk("err_sticky", 32'(bus.err), 1);
    do_reset();
    drive(1, 1, 1, 2, 1, 3, 1, 0, 0, 0);
    #2;
    chk("rst_err",    32'(bus.err),    0);
    chk("rst_halted", 32'(bus.halted), 0);
    chk("rst_stall",  32'(bus.stall),  0);
    tick();

    // Speculative halt squashed by flush returns to RUN.
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    #2 chk("spec_drain_stall", 32'(bus.stall), 1);
    tick();
    drive(1, 5, 1, 6, 1, 1, 1, 0, 0, 0);
    #2 chk("spec_run_stall", 32'(bus.stall), 0);
    tick();
    idle();
    for (int i = 0; i < 4; i++) begin
      #2 chk($sformatf("spec%0d_halted", i), 32'(bus.halted), 0);
      tick();
    end

    // Halt issued while draining flags err; reset mid-drain discards the halt.
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    #2 chk("drain_halt_err_pre", 32'(bus.err), 0);
    tick();
    idle();
    #2 chk("drain_halt_err", 32'(bus.err), 1);
    do_reset();
    drive(1, 1, 1, 2, 1, 3, 1, 0, 0, 0);
    #2 chk("middrain_rst_stall", 32'(bus.stall), 0);
    chk("middrain_rst_err", 32'(bus.err), 0);
    tick();
    idle();
    for (int i = 0; i < 4; i++) begin
      #2 chk($sformatf("middrain%0d_halted", i), 32'(bus.halted), 0);
      tick();
    end

    // Randomized traffic against the reference model.
    do_reset();
    m_reset();
    hcnt = 0;
    for (int n = 0; n < 3000; n++) begin
      hcnt = (m_mode == 2) ? hcnt + 1 : 0;
      rst = (hcnt > 4) || ($urandom_range(0, 199) == 0);
      drive($urandom_range(0, 3) != 0,
            3'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            3'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            3'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 2) == 0, $urandom_range(0, 29) == 0,
            $urandom_range(0, 5) == 0);
      bus.stage_data = {16'($urandom), 16'($urandom), 16'($urandom)};
      #2;
      m_check();
      @(posedge clk);
      m_advance();
      #1;
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
